beep_scheduler: RTL and testbench

BEEP_SCHEDULER -- requirements
Module: beep_scheduler

---
 rtl/beep_pkg.sv | 28 ++
 rtl/beep_scheduler_if.sv | 21 ++
 rtl/level_debounce.sv | 42 ++++
 rtl/beep_scheduler.sv | 136 +++++++++++++
 tb/tb_beep_scheduler.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/beep_pkg.sv
// Shared types and constants for the beep scheduler.
//   state_t      : scheduler FSM states
//   RATE_*       : active_rate / pending_rate encodings
//   CNT_W        : half-period counter width (covers 25_000_000-1)
//   clamp_rate   : folds levels 5..7 onto RATE_CONT
//   is_beep_rate : true for the four pulsed rates
package beep_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_CONT} state_t;

  localparam logic [2:0] RATE_OFF      = 3'd0;
  localparam logic [2:0] RATE_SLOWER   = 3'd1;
  localparam logic [2:0] RATE_SLOW     = 3'd2;
  localparam logic [2:0] RATE_MODERATE = 3'd3;
  localparam logic [2:0] RATE_FAST     = 3'd4;
  localparam logic [2:0] RATE_CONT     = 3'd5;

  localparam int CNT_W = $clog2(25_000_000);

  function automatic logic [2:0] clamp_rate(input logic [2:0] lvl);
    return (lvl > RATE_CONT) ? RATE_CONT : lvl;
  endfunction

  function automatic logic is_beep_rate(input logic [2:0] r);
    return (r >= RATE_SLOWER) && (r <= RATE_FAST);
  endfunction

endpackage

// File: rtl/beep_scheduler_if.sv
// Control/status bundle of the beep scheduler.
//   enable       : run enable (level)
//   level_valid  : one-cycle strobe qualifying level
//   level        : requested rate 0..7
//   beep_out     : buzzer drive
//   active_rate  : rate currently sounding 0..5
//   period_tick  : pulse on the last cycle of each ON+OFF period
// master drives the requests, slave is the scheduler.
interface beep_scheduler_if;
  logic       enable;
  logic       level_valid;
  logic [2:0] level;
  logic       beep_out;
  logic [2:0] active_rate;
  logic       period_tick;

  modport master (output enable, level_valid, level,
                  input  beep_out, active_rate, period_tick);
  modport slave  (input  enable, level_valid, level,
                  output beep_out, active_rate, period_tick);
endinterface

// File: rtl/level_debounce.sv
// Level debouncer: a level is accepted only after CONFIRM consecutive
// identical strobed samples. Accepted levels 5..7 collapse to RATE_CONT.
//   clk, rst     : clock, synchronous active-high reset
//   level_valid  : sample strobe
//   level        : sampled level
//   pending_rate : last accepted rate 0..5
module level_debounce
  import beep_pkg::*;
#(
  parameter int CONFIRM = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level_valid,
  input  logic [2:0] level,
  output logic [2:0] pending_rate
);

  localparam logic [3:0] CONF = 4'(CONFIRM);

  logic [2:0] cand;
  logic [3:0] cnt, cnt_nxt;

  // Count saturates at CONF so a long steady run never wraps.
  always_comb begin
    cnt_nxt = 4'd1;
    if (level == cand) cnt_nxt = (cnt >= CONF) ? cnt : cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand         <= RATE_OFF;
      cnt          <= '0;
      pending_rate <= RATE_OFF;
    end else if (level_valid) begin
      cand <= level;
      cnt  <= cnt_nxt;
      if (cnt_nxt == CONF) pending_rate <= clamp_rate(level);
    end
  end

endmodule

// File: rtl/beep_scheduler.sv
// Beep scheduler: turns a debounced rate request into a buzzer pattern of
// HALF cycles high / HALF cycles low, or a steady tone for RATE_CONT.
// Rate changes only take effect at period boundaries so beeps are never
// clipped.
//   clk, rst : clock, synchronous active-high reset
//   bus      : beep_scheduler_if.slave (enable/level in, beep/status out)
module beep_scheduler
  import beep_pkg::*;
#(
  parameter int HALF_SLOWER   = 25_000_000,
  parameter int HALF_SLOW     = 16_666_667,
  parameter int HALF_MODERATE = 12_500_000,
  parameter int HALF_FAST     = 5_000_000,
  parameter int CONFIRM       = 3
) (
  input  logic              clk,
  input  logic              rst,
  beep_scheduler_if.slave   bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, half_term;
  logic [2:0]       act, act_nxt, pend;
  logic             tick, beep_q;
  logic             term;

  level_debounce #(.CONFIRM(CONFIRM)) u_deb (
    .clk          (clk),
    .rst          (rst),
    .level_valid  (bus.level_valid),
    .level        (bus.level),
    .pending_rate (pend)
  );

  // Terminal count for the rate being played.
  always_comb begin
    case (act)
      RATE_SLOWER:   half_term = CNT_W'(HALF_SLOWER - 1);
      RATE_SLOW:     half_term = CNT_W'(HALF_SLOW - 1);
      RATE_MODERATE: half_term = CNT_W'(HALF_MODERATE - 1);
      RATE_FAST:     half_term = CNT_W'(HALF_FAST - 1);
      default:       half_term = '0;
    endcase
  end

  assign term = (cnt == half_term);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    act_nxt   = act;
    tick      = 1'b0;
    if (!bus.enable) begin
      // enable outranks everything, including a coincident period boundary
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      act_nxt   = RATE_OFF;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_beep_rate(pend)) begin
            state_nxt = ST_ON;
            act_nxt   = pend;
            cnt_nxt   = '0;
          end else if (pend == RATE_CONT) begin
            state_nxt = ST_CONT;
            act_nxt   = RATE_CONT;
            cnt_nxt   = '0;
          end
        end
        ST_ON: begin
          if (term) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_OFF: begin
          if (term) begin
            tick    = 1'b1;
            cnt_nxt = '0;
            if (pend == RATE_OFF) begin
              state_nxt = ST_IDLE;
              act_nxt   = RATE_OFF;
            end else if (pend == RATE_CONT) begin
              state_nxt = ST_CONT;
              act_nxt   = RATE_CONT;
            end else begin
              state_nxt = ST_ON;
              act_nxt   = pend;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_CONT: begin
          if (pend == RATE_OFF) begin
            state_nxt = ST_IDLE;
            act_nxt   = RATE_OFF;
          end else if (is_beep_rate(pend)) begin
            state_nxt = ST_ON;
            act_nxt   = pend;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          act_nxt   = RATE_OFF;
        end
      endcase
    end
  end

  // beep_q is loaded from state_nxt so it always equals the decode of
  // the registered state, yet comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      act    <= RATE_OFF;
      beep_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      act    <= act_nxt;
      beep_q <= (state_nxt == ST_ON) || (state_nxt == ST_CONT);
    end
  end

  assign bus.beep_out    = beep_q;
  assign bus.active_rate = act;
  assign bus.period_tick = tick & ~rst;

endmodule

// File: tb/tb_beep_scheduler.sv
// Directed bench for beep_scheduler with shortened half-periods
// (10/7/5/2) and CONFIRM=3. Outputs are sampled 1ns after each rising edge.
module tb_beep_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  beep_scheduler_if bus();

  beep_scheduler #(
    .HALF_SLOWER(10), .HALF_SLOW(7), .HALF_MODERATE(5), .HALF_FAST(2),
    .CONFIRM(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int b, input int a, input int t);
    chk({tag, ".beep"}, 32'(bus.beep_out),    b);
    chk({tag, ".rate"}, 32'(bus.active_rate), a);
    chk({tag, ".tick"}, 32'(bus.period_tick), t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [2:0] l);
    bus.level_valid = 1'b1;
    bus.level       = l;
    step();
    bus.level_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.enable      = 1'b0;
    bus.level_valid = 1'b0;
    bus.level       = 3'd0;

    // reset
    step(); step();
    chk_out("rst", 0, 0, 0);
    rst = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("rst_hold", 0, 0, 0);
    end

    // broken run 3,3,1 must not sound
    strobe(3); strobe(3); strobe(1);
    for (int i = 0; i < 4; i++) begin
      chk_out("deb_broken", 0, 0, 0);
      step();
    end

    // 3,3,3 -> rate 3, beep at t+2, 5 high / 5 low, tick every 10
    strobe(3); strobe(3); strobe(3);
    chk_out("lat_t1", 0, 0, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      chk_out("rate3", int'((i % 10) < 5), 3, int'((i % 10) == 9));
      step();
    end

    // disable, confirm rate 1 while disabled, then re-enable
    bus.enable = 1'b0;
    step();
    chk_out("dis", 0, 0, 0);
    strobe(1); strobe(1); strobe(1);
    chk_out("dis_conf", 0, 0, 0);
    bus.enable = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk_out("r1_pre", 1, 1, 0);
      if (i == 3) bus.enable = 1'b0;
      step();
    end
    chk_out("drop", 0, 0, 0);
    bus.enable = 1'b1;
    step();

    // full rate-1 period without re-confirm; rate 4 confirmed at ON cycle 4
    for (int i = 0; i < 28; i++) begin
      if (i < 20)
        chk_out("defer_r1", int'(i < 10), 1, int'(i == 19));
      else
        chk_out("defer_r4", int'(((i - 20) % 4) < 2), 4, int'(((i - 20) % 4) == 3));
      if (i >= 1 && i <= 3) begin
        bus.level_valid = 1'b1;
        bus.level       = 3'd4;
      end else begin
        bus.level_valid = 1'b0;
      end
      step();
    end
    bus.level_valid = 1'b0;

    // level 6 -> continuous tone after the current rate-4 period
    strobe(6); strobe(6); strobe(6);
    chk_out("r4_end", 0, 4, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk_out("cont", 1, 5, 0);
      step();
    end
    strobe(0); strobe(0); strobe(0);
    chk_out("cont_last", 1, 5, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk_out("cont_off", 0, 0, 0);
      step();
    end

    // rate 2, reset during OFF, fresh confirmation required
    strobe(2); strobe(2); strobe(2);
    chk_out("r2_lat", 0, 0, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      chk_out("rate2", int'(i < 7), 2, 0);
      if (i == 9) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    chk_out("mid_rst", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("post_rst", 0, 0, 0);
    end
    strobe(2); strobe(2);
    for (int i = 0; i < 3; i++) begin
      chk_out("post_rst_2of3", 0, 0, 0);
      step();
    end
    strobe(2);
    chk_out("reconf_t1", 0, 0, 0);
    step();
    for (int i = 0; i < 9; i++) begin
      chk_out("reconf", int'(i < 7), 2, 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
